cpu64_obi_host_pipelined: RTL
=============================

Name: cpu64_obi_host_pipelined

Overview:
Pipelined OBI host driver. It replaces the single-outstanding fetch/load driver with one that issues up to MAX_OUTSTANDING back-to-back requests and returns in-order responses tagged with the host's transaction tag. It sits between a pipeline stage (IMEM fetch or DMEM LSU) and the OBI memory port. The host uses a valid/ready handshake; OBI address-phase stability is guaranteed internally by a one-entry hold register.

Parameters:
DATA_W, 64, data width.
ADDR_W, 39, address width.
BE_BITS, DATA_W/8, byte-enable width.
TAG_W, 4, width of host transaction tag carried through to the response.
MAX_OUTSTANDING, 2, maximum granted-but-unanswered transactions (>=1).
CNT_W, $clog2(MAX_OUTSTANDING+1), outstanding-counter width.

Ports:
clk_i  in  1  clock.
rst_i  in  1  reset, asynchronous, active-high.
hreq_valid_i  in  1  host request valid.
hreq_ready_o  out  1  host request accepted when valid&ready.
hreq_we_i  in  1  write (1) / read (0).
hreq_be_i  in  BE_BITS  byte enables.
hreq_addr_i  in  ADDR_W  address.
hreq_wdata_i  in  DATA_W  write data.
hreq_tag_i  in  TAG_W  host tag.
hrsp_valid_o  out  1  response valid (one cycle; no backpressure).
hrsp_rdata_o  out  DATA_W  read data (passthrough of rdata_i).
hrsp_we_o  out  1  response belongs to a write.
hrsp_tag_o  out  TAG_W  tag of the responding transaction.
hrsp_err_o  out  1  bus error for this transaction.
req_o  out  1  OBI request.
gnt_i  in  1  OBI grant.
we_o  out  1  OBI write enable.
be_o  out  BE_BITS  OBI byte enable.
addr_o  out  ADDR_W  OBI address.
wdata_o  out  DATA_W  OBI write data.
rvalid_i  in  1  OBI response valid.
rdata_i  in  DATA_W  OBI read data.
err_i  in  1  OBI error.
outstanding_o  out  CNT_W  current outstanding count.
idle_o  out  1  hold register empty and outstanding_o==0.
proto_err_o  out  1  sticky: rvalid_i seen with outstanding_o==0.

Behaviour:
- Reset (async, rst_i=1): hold_valid=0, count=0, FIFO empty, proto_err_o=0. Outputs: req_o=0, hreq_ready_o=1, hrsp_valid_o=0, outstanding_o=0, idle_o=1. Address/data outputs are 0 (driven from the cleared hold register).
- Hold register: one entry {we, be, addr, wdata, tag}. It loads on hreq_valid_i&hreq_ready_o. hreq_ready_o = ~hold_valid | issue, where issue = req_o & gnt_i (same-cycle refill, zero bubble).
- req_o = hold_valid & (count < MAX_OUTSTANDING). Address-phase outputs come straight from the hold register, so they stay stable from req_o rise until gnt_i. Once raised, req_o cannot drop before grant, because count only decreases while ungranted.
- Latency: host accept in cycle N gives req_o in cycle N+1. With gnt_i=1 constantly, throughput is 1 transaction/cycle until count saturates.
- Tag FIFO: depth MAX_OUTSTANDING, entries {we, tag}. Push on issue; pop on rvalid_i. In-order completion is assumed per OBI.
- Response path: hrsp_valid_o = rvalid_i & (count!=0). hrsp_rdata_o=rdata_i and hrsp_err_o=err_i (combinational). hrsp_we_o and hrsp_tag_o come from the FIFO head.
- Counter: issue only → +1; rvalid only → -1; both → unchanged; saturation is impossible by construction.
- Same-cycle grant and response: the response belongs to the FIFO head (an older transaction), never to the one granted this cycle. The earliest response is the cycle after grant.
- rvalid_i with count==0: ignored (no pop, no hrsp_valid_o), and proto_err_o is set until reset.
- An error response still pops and decrements. It does not block subsequent traffic.
- Reset mid-transaction: all state is dropped immediately. A late rvalid_i after reset sets proto_err_o.

Test Plan:
- Single read: tag=3, addr=0x100, gnt_i=1; rvalid_i at +2 with rdata=0xDEAD → req_o for 1 cycle, hrsp_valid_o=1 with tag=3, we=0, rdata=0xDEAD; outstanding_o goes 0→1→0.
- Back-to-back, MAX_OUTSTANDING=2: 4 reads (tags 1..4) with gnt_i=1 and rvalid_i delayed 3 cycles → at most 2 outstanding, req_o low while count==2, hreq_ready_o stalls, responses arrive in tag order 1,2,3,4.
- Grant stall: gnt_i=0 for 5 cycles during a write (addr=0x40, wdata=0x1122, be=0xF0) → req_o, addr_o, wdata_o, be_o and we_o constant every stalled cycle; hreq_ready_o=0; single issue when gnt_i=1.
- Simultaneous grant and response at count=1 → count stays 1; the response carries the older tag.
- Error and protocol error: err_i=1 on the 2nd response → hrsp_err_o=1 with the correct tag and traffic continues. Spurious rvalid_i while idle → proto_err_o=1 and sticky.
- Async reset asserted with 2 outstanding → outputs return to reset values without a clock edge; idle_o=1.

Source files
------------

// File: rtl/cpu64_obi_host_pipelined.sv
// rtl/cpu64_obi_host_pipelined.sv - pipelined OBI host driver with tag FIFO and hold register
`timescale 1ns/1ps
module cpu64_obi_host_pipelined #(
    parameter int DATA_W          = 64,
    parameter int ADDR_W          = 39,
    parameter int BE_BITS         = DATA_W/8,
    parameter int TAG_W           = 4,
    parameter int MAX_OUTSTANDING = 2,
    parameter int CNT_W           = $clog2(MAX_OUTSTANDING+1)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               hreq_valid_i,
    output logic               hreq_ready_o,
    input  logic               hreq_we_i,
    input  logic [BE_BITS-1:0] hreq_be_i,
    input  logic [ADDR_W-1:0]  hreq_addr_i,
    input  logic [DATA_W-1:0]  hreq_wdata_i,
    input  logic [TAG_W-1:0]   hreq_tag_i,
    output logic               hrsp_valid_o,
    output logic [DATA_W-1:0]  hrsp_rdata_o,
    output logic               hrsp_we_o,
    output logic [TAG_W-1:0]   hrsp_tag_o,
    output logic               hrsp_err_o,
    output logic               req_o,
    input  logic               gnt_i,
    output logic               we_o,
    output logic [BE_BITS-1:0] be_o,
    output logic [ADDR_W-1:0]  addr_o,
    output logic [DATA_W-1:0]  wdata_o,
    input  logic               rvalid_i,
    input  logic [DATA_W-1:0]  rdata_i,
    input  logic               err_i,
    output logic [CNT_W-1:0]   outstanding_o,
    output logic               idle_o,
    output logic               proto_err_o
);
    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    logic               hold_valid;
    logic               hold_we;
    logic [BE_BITS-1:0] hold_be;
    logic [ADDR_W-1:0]  hold_addr;
    logic [DATA_W-1:0]  hold_wdata;
    logic [TAG_W-1:0]   hold_tag;

    logic [CNT_W-1:0]   count;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic               fifo_we  [MAX_OUTSTANDING];
    logic [TAG_W-1:0]   fifo_tag [MAX_OUTSTANDING];
    logic               proto_err;

    logic issue;
    logic pop;
    logic accept;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(MAX_OUTSTANDING-1)) ? '0 : p + 1'b1;
    endfunction

    // count only falls while req_o is waiting, so req_o never drops before grant
    assign req_o        = hold_valid && (count < CNT_W'(MAX_OUTSTANDING));
    assign issue        = req_o && gnt_i;
    assign pop          = rvalid_i && (count != '0);
    assign hreq_ready_o = ~hold_valid | issue;
    assign accept       = hreq_valid_i && hreq_ready_o;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hold_valid <= 1'b0;
            hold_we    <= 1'b0;
            hold_be    <= '0;
            hold_addr  <= '0;
            hold_wdata <= '0;
            hold_tag   <= '0;
        end else if (accept) begin
            hold_valid <= 1'b1;
            hold_we    <= hreq_we_i;
            hold_be    <= hreq_be_i;
            hold_addr  <= hreq_addr_i;
            hold_wdata <= hreq_wdata_i;
            hold_tag   <= hreq_tag_i;
        end else if (issue) begin
            hold_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                fifo_we[i]  <= 1'b0;
                fifo_tag[i] <= '0;
            end
        end else begin
            if (issue) begin
                fifo_we[wr_ptr]  <= hold_we;
                fifo_tag[wr_ptr] <= hold_tag;
                wr_ptr           <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count     <= '0;
            proto_err <= 1'b0;
        end else begin
            case ({issue, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (rvalid_i && (count == '0)) begin
                proto_err <= 1'b1;
            end
        end
    end

    assign we_o          = hold_we;
    assign be_o          = hold_be;
    assign addr_o        = hold_addr;
    assign wdata_o       = hold_wdata;
    assign hrsp_valid_o  = pop;
    assign hrsp_rdata_o  = rdata_i;
    assign hrsp_err_o    = err_i;
    assign hrsp_we_o     = fifo_we[rd_ptr];
    assign hrsp_tag_o    = fifo_tag[rd_ptr];
    assign outstanding_o = count;
    assign idle_o        = ~hold_valid && (count == '0);
    assign proto_err_o   = proto_err;
endmodule
